// File: rtl/nibble_add_pkg.sv
// Shared types and default sizing for the nibble-serial adder.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF  = 16;
  localparam int SLICE_DEF  = 4;
  localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;
  localparam int NIDX_W_DEF = (NSLICE_DEF > 1) ? $clog2(NSLICE_DEF) : 1;

endpackage

// File: rtl/nibble_serial_adder16_add_slice4.sv
// Combinational SLICE-bit ripple-carry slice built from full adders.
module add_slice4 #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/nibble_serial_adder16.sv
// Multi-cycle WIDTH-bit adder driving one SLICE-bit slice per clock, LSB first.
// Optional signed-overflow output enabled by defining NIBBLE_ADD_OVF_EN.
module nibble_serial_adder16
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef NIBBLE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  // Handshake: a transfer happens only on valid && ready at a rising edge;
  // sum/cout are frozen from the last RUN edge until out_ready drains DONE.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SLICE-1:0] slice_a, slice_b, slice_s;
  logic             slice_co;
`ifdef NIBBLE_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    slice_a = a_q[idx_q*SLICE +: SLICE];
    slice_b = b_q[idx_q*SLICE +: SLICE];
  end

  add_slice4 #(.SLICE(SLICE)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef NIBBLE_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef NIBBLE_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef NIBBLE_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = slice_s;
        carry_d = slice_co;
        if (idx_q == LAST_IDX) begin
          idx_d  = '0;
          cout_d = slice_co;
`ifdef NIBBLE_ADD_OVF_EN
          // Carry into the MSB is recovered as a ^ b ^ s at that bit.
          ovf_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[SLICE-1]) ^ slice_co;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sum       = sum_q;
    cout      = cout_q;
`ifdef NIBBLE_ADD_OVF_EN
    ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_nibble_serial_adder16.sv
// Scoreboard bench for nibble_serial_adder16; checks ovf too when NIBBLE_ADD_OVF_EN is defined.
module tb_nibble_serial_adder16;

`ifdef NIBBLE_ADD_OVF_EN
  localparam int EW = 18;
`else
  localparam int EW = 17;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
`ifdef NIBBLE_ADD_OVF_EN
  logic        ovf;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [EW-1:0] exp_q[$];
  logic man_ready = 1'b0;
  logic rnd_ready = 1'b0;

  nibble_serial_adder16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef NIBBLE_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : man_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: plain integer arithmetic
  function automatic logic [EW-1:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic cv);
    logic [16:0] full;
    int signed   s;
    logic        v;
    full = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
    s = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    v = (s > 32767) || (s < -32768);
`ifdef NIBBLE_ADD_OVF_EN
    return {v, full};
`else
    if (v) return full;
    return full;
`endif
  endfunction

  // driver
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("send_wait_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    @(posedge clk);
    exp_q.push_back(model(av, bv, cv));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor / scoreboard
  logic          hold_v = 1'b0;
  logic [EW-1:0] hold_val;
  logic [EW-1:0] act;

  always @(negedge clk) begin
`ifdef NIBBLE_ADD_OVF_EN
    act = {ovf, cout, sum};
`else
    act = {cout, sum};
`endif
    if (rst_n && out_valid) begin
      if (hold_v) chk("hold_stable", 32'(act), 32'(hold_val));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(act), 32'hDEAD);
        end else begin
          chk("result", 32'(act), 32'(exp_q.pop_front()));
        end
        hold_v = 1'b0;
      end else begin
        hold_v   = 1'b1;
        hold_val = act;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // latency: accept edge counts as edge 1; out_valid must follow edge NSLICE+1
    man_ready = 1'b0;
    send(16'h0000, 16'h000A, 1'b0);
    for (k = 2; k <= 12; k++) begin
      @(posedge clk);
      #2;
      if (out_valid) break;
    end
    chk("latency_edges", 32'(k), 32'd5);
    man_ready = 1'b1;
    drain();

    send(16'hFFFF, 16'h0001, 1'b0);
    drain();
    send(16'h7FFF, 16'h0001, 1'b0);
    drain();
    send(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // backpressure with an ignored second request
    man_ready = 1'b0;
    repeat (2) @(posedge clk);
    send(16'h1100, 16'h0011, 1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h0000;
        cin = 1'b0;
      end
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h1111);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    man_ready = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(out_valid), 32'd0);
    drain();

    // asynchronous reset during the second RUN cycle
    send(16'h1001, 16'h0000, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0003, 16'h0004, 1'b1);
    drain();

    // random back-to-back with random consumer stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    rnd_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
